// File: rtl/counter_time_pkg.sv
// Shared constants and FSM encoding for the configurable count timer.
// Counter and bench both import this so direction/mode values agree.
package counter_time_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles by DIV; tick is asserted combinationally in
// the enabled cycle where the internal count sits at DIV-1.
module tick_prescaler #(
  parameter int DIV = 1
) (
  input  logic clkt,
  input  logic R,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count only advances when enabled, so a deasserted enable freezes phase.
  always_ff @(posedge clkt) begin
    if (R || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_time_cfg.sv
// Configurable up/down timer with wrap or one-shot behaviour and a prescaled
// count tick. FSM state is held in the named register 'state'.
module counter_time_cfg
  import counter_time_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PRESC_DIV = 1
) (
  input  logic             clkt,
  input  logic             R,
  input  logic             E,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] tempo,
  output logic             end_time,
  output logic             done,
  output logic             running
);

  // Control handshake: start and load are single-cycle pulses sampled on the
  // rising edge with no ready; both are always accepted, priority
  // R > load > start > tick, and outputs reflect them one cycle later.

  state_e           state, state_next;
  logic [WIDTH-1:0] tempo_next;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] load_sat;
  logic             end_next;
  logic             terminal;
  logic             tick;
  logic             presc_en;
  logic             presc_clr;

  assign start_val = (dir == DIR_DOWN) ? limit : '0;
  assign load_sat  = (load_val > limit) ? limit : load_val;
  assign terminal  = (dir == DIR_UP) ? (tempo >= limit) : (tempo == '0);
  assign presc_en  = E && (state == ST_RUN);
  assign presc_clr = load || start;

  tick_prescaler #(
    .DIV (PRESC_DIV)
  ) u_presc (
    .clkt (clkt),
    .R    (R),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    tempo_next = tempo;
    end_next   = 1'b0;
    if (load) begin
      tempo_next = load_sat;
      if (state == ST_DONE) state_next = ST_IDLE;
    end else if (start) begin
      tempo_next = start_val;
      state_next = ST_RUN;
    end else if (tick) begin
      if (terminal) begin
        end_next = 1'b1;
        // One-shot holds the terminal value; wrap reloads and keeps running.
        if (mode == MODE_ONESHOT) begin
          state_next = ST_DONE;
        end else begin
          tempo_next = start_val;
        end
      end else if (dir == DIR_DOWN) begin
        tempo_next = tempo - WIDTH'(1);
      end else begin
        tempo_next = tempo + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clkt) begin
    if (R) begin
      state    <= ST_IDLE;
      tempo    <= '0;
      end_time <= 1'b0;
      done     <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_next;
      tempo    <= tempo_next;
      end_time <= end_next;
      done     <= (state_next == ST_DONE);
      running  <= (state_next == ST_RUN);
    end
  end

endmodule

// File: tb/tb_counter_time_cfg.sv
// Directed bench for counter_time_cfg: one instance with no prescaling and one
// with PRESC_DIV=3, each checked every cycle against a queue of expectations.
module tb_counter_time_cfg;
  import counter_time_pkg::*;

  localparam int W = 4;

  // clock / reset block
  logic clkt = 1'b0;
  always #5 clkt = ~clkt;

  logic         r = 1'b1, e = 1'b0, start = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0, limit = '0;
  logic         dir = DIR_UP, mode = MODE_WRAP;
  logic [W-1:0] tempo;
  logic         end_time, done, running;

  logic         r3 = 1'b1, e3 = 1'b0, start3 = 1'b0, load3 = 1'b0;
  logic [W-1:0] load_val3 = '0, limit3 = '0;
  logic         dir3 = DIR_UP, mode3 = MODE_WRAP;
  logic [W-1:0] tempo3;
  logic         end_time3, done3, running3;

  counter_time_cfg #(.WIDTH(W), .PRESC_DIV(1)) u_dut (
    .clkt(clkt), .R(r), .E(e), .start(start), .load(load), .load_val(load_val),
    .limit(limit), .dir(dir), .mode(mode), .tempo(tempo), .end_time(end_time),
    .done(done), .running(running)
  );

  counter_time_cfg #(.WIDTH(W), .PRESC_DIV(3)) u_dut3 (
    .clkt(clkt), .R(r3), .E(e3), .start(start3), .load(load3), .load_val(load_val3),
    .limit(limit3), .dir(dir3), .mode(mode3), .tempo(tempo3), .end_time(end_time3),
    .done(done3), .running(running3)
  );

  // scoreboard: {tempo, end_time, done, running}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] exp3_q[$];
  logic [W+2:0] exp_v, exp3_v, act_v, act3_v;
  int           tests = 0;
  int           failures = 0;
  logic         drain_chk = 1'b0;
  logic         drained = 1'b0;
  string        phase = "reset";

  // driver tasks: inputs are already set; wait one edge, record expectation
  task automatic cyc(input logic [W-1:0] t, input logic et, input logic dn, input logic rn);
    @(posedge clkt);
    exp_q.push_back({t, et, dn, rn});
    #1;
  endtask

  task automatic cyc3(input logic [W-1:0] t, input logic et, input logic dn, input logic rn);
    @(posedge clkt);
    exp3_q.push_back({t, et, dn, rn});
    #1;
  endtask

  // monitor
  always @(negedge clkt) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {tempo, end_time, done, running};
      tests++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL dut1 %s t=%0t got tempo=%0d end=%b done=%b run=%b, want tempo=%0d end=%b done=%b run=%b",
                 phase, $time, act_v[W+2:3], act_v[2], act_v[1], act_v[0],
                 exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    if (exp3_q.size() > 0) begin
      exp3_v = exp3_q.pop_front();
      act3_v = {tempo3, end_time3, done3, running3};
      tests++;
      if (act3_v !== exp3_v) begin
        failures++;
        $display("FAIL dut3 %s t=%0t got tempo=%0d end=%b done=%b run=%b, want tempo=%0d end=%b done=%b run=%b",
                 phase, $time, act3_v[W+2:3], act3_v[2], act3_v[1], act3_v[0],
                 exp3_v[W+2:3], exp3_v[2], exp3_v[1], exp3_v[0]);
      end
    end
    if (drain_chk && !drained) begin
      tests++;
      if (exp_q.size() != 0 || exp3_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending got %0d/%0d entries, want 0/0", exp_q.size(), exp3_q.size());
      end
      drained = 1'b1;
    end
  end

  logic [39:0] epat;
  int          h;

  initial begin
    // reset
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    r = 1'b0;

    // decade count, wrap every 10 ticks
    phase = "decade";
    limit = 4'd9; dir = DIR_UP; mode = MODE_WRAP; e = 1'b1;
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    for (int n = 1; n < 30; n++) cyc(W'(n % 10), (n % 10) == 0, 0, 1);

    // reset mid-run at tempo 7, then restart from 0
    phase = "reset_mid";
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    for (int n = 1; n <= 7; n++) cyc(W'(n), 0, 0, 1);
    r = 1'b1; cyc(0, 0, 0, 0); r = 1'b0;
    cyc(0, 0, 0, 0);
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    cyc(1, 0, 0, 1);
    cyc(2, 0, 0, 1);

    // load saturates at limit; load beats a terminal tick
    phase = "load";
    load_val = 4'd12; load = 1'b1; cyc(9, 0, 0, 1);
    load_val = 4'd3;  cyc(3, 0, 0, 1); load = 1'b0;
    for (int n = 4; n <= 9; n++) cyc(W'(n), 0, 0, 1);
    cyc(0, 1, 0, 1);

    // limit 0: every tick terminal, tempo pinned at 0
    phase = "limit0";
    limit = 4'd0;
    repeat (4) cyc(0, 1, 0, 1);
    dir = DIR_DOWN;
    repeat (2) cyc(0, 1, 0, 1);
    dir = DIR_UP; limit = 4'd9;

    // limit lowered below tempo while counting up
    phase = "limit_drop";
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    for (int n = 1; n <= 6; n++) cyc(W'(n), 0, 0, 1);
    limit = 4'd3;
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1); cyc(2, 0, 0, 1); cyc(3, 0, 0, 1);
    cyc(0, 1, 0, 1);

    // direction change mid-run, then E low freezes
    phase = "dir_change";
    limit = 4'd9;
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    cyc(1, 0, 0, 1); cyc(2, 0, 0, 1); cyc(3, 0, 0, 1);
    dir = DIR_DOWN;
    cyc(2, 0, 0, 1); cyc(1, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(9, 1, 0, 1);
    cyc(8, 0, 0, 1);
    e = 1'b0;
    repeat (3) cyc(8, 0, 0, 1);
    e = 1'b1;
    cyc(7, 0, 0, 1);

    // one-shot down from 5
    phase = "oneshot_down";
    limit = 4'd5; dir = DIR_DOWN; mode = MODE_ONESHOT;
    start = 1'b1; cyc(5, 0, 0, 1); start = 1'b0;
    for (int n = 4; n >= 0; n--) cyc(W'(n), 0, 0, 1);
    cyc(0, 1, 1, 0);
    repeat (20) cyc(0, 0, 1, 0);

    // load from DONE returns to IDLE; priorities
    phase = "priority";
    load_val = 4'd3; load = 1'b1; cyc(3, 0, 0, 0); load = 1'b0;
    cyc(3, 0, 0, 0);
    load_val = 4'd7; load = 1'b1; start = 1'b1; cyc(5, 0, 0, 0);
    r = 1'b1; cyc(0, 0, 0, 0);
    r = 1'b0; load = 1'b0; start = 1'b0;

    // one-shot up to 2, restart from DONE
    phase = "oneshot_up";
    limit = 4'd2; dir = DIR_UP; mode = MODE_ONESHOT;
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    cyc(1, 0, 0, 1); cyc(2, 0, 0, 1);
    cyc(2, 1, 1, 0); cyc(2, 0, 1, 0);
    start = 1'b1; cyc(0, 0, 0, 1); start = 1'b0;
    cyc(1, 0, 0, 1);
    r = 1'b1; cyc(0, 0, 0, 0); r = 1'b0;

    // prescaler by 3 with E toggled
    phase = "prescaler";
    cyc3(0, 0, 0, 0);
    r3 = 1'b0; limit3 = 4'd9; dir3 = DIR_UP; mode3 = MODE_WRAP;
    start3 = 1'b1; cyc3(0, 0, 0, 1); start3 = 1'b0;
    epat = 40'b1111_1111_1111_0011_1111_1101_1110_0111_1101_1011;
    h = 0;
    for (int i = 0; i < 40; i++) begin
      e3 = epat[i];
      if (e3) h++;
      cyc3(W'((h / 3) % 10), e3 && (h % 3 == 0) && ((h / 3) % 10 == 0), 0, 1);
    end
    e3 = 1'b0;
    cyc3(W'((h / 3) % 10), 0, 0, 1);

    // final report
    drain_chk = 1'b1;
    repeat (3) @(posedge clkt);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/counter_time_cfg.md
COUNTER_TIME_CFG -- requirements
Module: counter_time_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, at least 1.
REQ-002 SHALL have parameter PRESC_DIV, default 1: enabled clkt cycles per count tick, at least 1.
REQ-003 SHALL have port clkt, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port R, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port E, input, 1 bit: count enable; gates both the prescaler and counting.
REQ-006 SHALL have port start, input, 1 bit: pulse; begins or restarts a count run.
REQ-007 SHALL have port load, input, 1 bit: pulse; loads load_val into tempo.
REQ-008 SHALL have port load_val, input, WIDTH bits: value for load.
REQ-009 SHALL have port limit, input, WIDTH bits: terminal value, unsigned.
REQ-010 SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down.
REQ-011 SHALL have port mode, input, 1 bit: 0 wrap (continuous), 1 one-shot.
REQ-012 SHALL have port tempo, output, WIDTH bits: current count.
REQ-013 SHALL have port end_time, output, 1 bit: one-cycle pulse on terminal tick.
REQ-014 SHALL have port done, output, 1 bit: high while in DONE.
REQ-015 SHALL have port running, output, 1 bit: high while in RUN.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 SHALL define the start value as 0 when dir=0 and as limit when dir=1.
REQ-018 SHALL define a tick as a cycle in which state=RUN, E=1 and the prescaler reaches PRESC_DIV-1; PRESC_DIV=1 makes every such cycle a tick.
REQ-019 SHALL hold the prescaler when E=0 or state!=RUN, and clear it on R, load or start.
REQ-020 SHALL, on start in any state, set tempo to the start value and go to RUN on the next edge.
REQ-021 SHALL, on a non-terminal tick, increment tempo when dir=0 and decrement it when dir=1.
REQ-022 SHALL treat a tick as terminal when dir=0 and tempo>=limit, or when dir=1 and tempo==0.
REQ-023 SHALL, on a terminal tick with mode=0, set tempo to the start value, pulse end_time for one cycle and stay in RUN.
REQ-024 SHALL, on a terminal tick with mode=1, hold tempo, pulse end_time for one cycle and go to DONE.
REQ-025 SHALL register all outputs: end_time rises in the same cycle tempo takes its post-terminal value.
REQ-026 SHALL, on load in any state, set tempo to min(load_val, limit), produce no end_time, send DONE to IDLE and leave other states unchanged.
REQ-027 SHALL apply the priority R > load > start > tick.
REQ-028 SHALL, when limit=0, make every tick terminal with tempo remaining 0.
REQ-029 SHALL, when dir changes mid-run, apply the new direction from the next tick without reloading tempo.
REQ-030 SHALL, when limit is lowered below tempo while counting up, wrap or stop on the next tick per REQ-023 and REQ-024.
REQ-031 SHALL use modulo-2^WIDTH arithmetic and never let tempo leave 0..2^WIDTH-1.

Reset
REQ-032 SHALL, on R=1 at a clkt edge, set tempo=0, end_time=0, done=0, running=0, prescaler=0 and state=IDLE.
REQ-033 SHALL let R during RUN or DONE override every other input in that cycle, with no end_time pulse.

Structure
REQ-034 SHALL place state encodings and the DIR_UP/DIR_DOWN and MODE_WRAP/MODE_ONESHOT constants in shared package counter_time_pkg.
REQ-035 SHALL implement the prescaler as sub-module tick_prescaler (inputs clkt, R, clr, en; parameter DIV; output tick).
REQ-036 SHALL keep the FSM and counter datapath in counter_time_cfg.

Verification
REQ-037 SHALL verify a decade count: WIDTH=4, PRESC_DIV=1, limit=9, dir=0, mode=0, start then E=1 -> tempo 0..9 then 0, end_time high only in the cycle tempo returns to 0, repeating every 10 cycles.
REQ-038 SHALL verify a one-shot down count: limit=5, dir=1, mode=1, start -> tempo 5,4,3,2,1,0, end_time pulses once, done=1, tempo holds 0 for 20 more cycles.
REQ-039 SHALL verify the prescaler: PRESC_DIV=3, limit=9, E toggled -> tempo advances once per 3 E-high cycles and the prescaler freezes while E=0.
REQ-040 SHALL verify load: load_val=12 with limit=9 -> tempo=9; load coincident with a terminal tick -> load wins and end_time=0.
REQ-041 SHALL verify reset mid-run: R=1 while tempo=7 in RUN -> next cycle tempo=0 and state IDLE; start then resumes counting from 0.
REQ-042 SHALL verify limit=0 in wrap mode -> end_time on every tick and tempo stays 0.
